// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks the H/V counters, issues framebuffer pixel
// requests, and delays sync/blank to line up with the returned pixel data.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1680,
    parameter int H_FP     = 104,
    parameter int H_SYNC   = 184,
    parameter int H_BP     = 288,
    parameter int V_ACTIVE = 1050,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b1,
    parameter int PIPE     = 2,
    parameter int PIX_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             req_valid,
    output logic [11:0]      req_x,
    output logic [10:0]      req_y,
    input  logic [PIX_W-1:0] pix_in,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_de,
    output logic [PIX_W-1:0] vga_rgb,
    output logic             sof,
    output logic [15:0]      frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] HS_BEGIN = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic sof;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0, sof: 1'b0};

    logic [11:0] hcnt;
    logic [10:0] vcnt;

    logic        act_n;
    logic        hs_n;
    logic        vs_n;
    logic        sof_n;

    logic        hs0;
    logic        vs0;
    logic        sof0;
    logic        s0_live;

    ctl_t        dly_in;
    ctl_t        dly [PIPE];

    // Raster position counters and frame counter, advanced only while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt      <= '0;
            vcnt      <= '0;
            frame_cnt <= '0;
        end else if (en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                if (vcnt == V_LAST) begin
                    vcnt      <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    vcnt <= vcnt + 11'd1;
                end
            end else begin
                hcnt <= hcnt + 12'd1;
            end
        end
    end

    // Decode region membership of the current count value
    always_comb begin
        act_n = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_n  = ((hcnt >= HS_BEGIN) && (hcnt < HS_END)) ? H_POL : ~H_POL;
        vs_n  = ((vcnt >= VS_BEGIN) && (vcnt < VS_END)) ? V_POL : ~V_POL;
        sof_n = act_n && (hcnt == '0) && (vcnt == '0);
    end

    // Stage 0: request outputs and raw sync; holds while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid <= 1'b0;
            req_x     <= '0;
            req_y     <= '0;
            hs0       <= ~H_POL;
            vs0       <= ~V_POL;
            sof0      <= 1'b0;
            s0_live   <= 1'b0;
        end else begin
            s0_live <= en;
            if (en) begin
                req_valid <= act_n;
                req_x     <= act_n ? hcnt : '0;
                req_y     <= act_n ? vcnt : '0;
                hs0       <= hs_n;
                vs0       <= vs_n;
                sof0      <= sof_n;
            end
        end
    end

    // Only a freshly issued stage-0 value enters the delay line; a held request
    // feeds idle instead, so a pause emits each pixel once and drains cleanly.
    always_comb begin
        dly_in = CTL_IDLE;
        if (s0_live) begin
            dly_in = '{hs: hs0, vs: vs0, de: req_valid, sof: sof0};
        end
    end

    // Control delay line matching the framebuffer read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PIPE; i++) begin
                dly[i] <= CTL_IDLE;
            end
        end else begin
            dly[0] <= dly_in;
            for (int unsigned i = 1; i < PIPE; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // Output stage: sync, DE, SOF and pixel data registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hsync <= ~H_POL;
            vga_vsync <= ~V_POL;
            vga_de    <= 1'b0;
            sof       <= 1'b0;
            vga_rgb   <= '0;
        end else begin
            vga_hsync <= dly[PIPE-1].hs;
            vga_vsync <= dly[PIPE-1].vs;
            vga_de    <= dly[PIPE-1].de;
            sof       <= dly[PIPE-1].sof;
            vga_rgb   <= dly[PIPE-1].de ? pix_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small raster, with a
// position-based reference model and a randomized framebuffer.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 1, HT = 14;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
    localparam int FRAME = HT * VT;
    localparam int PIPE  = 2;
    localparam int PW    = 24;
    localparam bit HP    = 1'b0;
    localparam bit VP    = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [PW-1:0] pix_in = '0;
    logic          req_valid;
    logic [11:0]   req_x;
    logic [10:0]   req_y;
    logic          vga_hsync;
    logic          vga_vsync;
    logic          vga_de;
    logic [PW-1:0] vga_rgb;
    logic          sof;
    logic [15:0]   frame_cnt;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(HP), .V_POL(VP), .PIPE(PIPE), .PIX_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .pix_in(pix_in),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_rgb(vga_rgb), .sof(sof), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit live;
        int pos;
    } rec_t;

    int          checks = 0;
    int          errors = 0;
    logic [PW-1:0] fb [VA][HA];
    rec_t        hist[$];
    logic [PW-1:0] hq[$];
    int          t   = 0;   // enabled edges since reset = next raster position
    int          cyc = 0;   // edges since reset release
    bit          pin = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cyc %0d, t=%0t)", nm, a, e, cyc, $time);
        end
    endtask

    // Reference: each position p maps to (p%HT, (p/HT)%VT); outputs show the
    // stage-0 record from PIPE+1 edges earlier, or idle if none was issued.
    task automatic check_all();
        int p, x, y, ox, oy;
        bit v, live, de;
        rec_t r;
        p = t - 1;
        x = (p < 0) ? 0 : p % HT;
        y = (p < 0) ? 0 : (p / HT) % VT;
        v = (t > 0) && (x < HA) && (y < VA);
        chk("req_valid", req_valid, v);
        chk("req_x", req_x, v ? x : 0);
        chk("req_y", req_y, v ? y : 0);
        chk("frame_cnt", frame_cnt, (t / FRAME) % 65536);
        live = 1'b0;
        r.pos = 0;
        if (hist.size() >= PIPE + 2) begin
            r = hist[hist.size() - PIPE - 2];
            live = r.live;
        end
        ox = r.pos % HT;
        oy = (r.pos / HT) % VT;
        de = live && (ox < HA) && (oy < VA);
        chk("vga_de", vga_de, de);
        chk("vga_hsync", vga_hsync,
            (live && ox >= HA + HF && ox < HA + HF + HS) ? HP : !HP);
        chk("vga_vsync", vga_vsync,
            (live && oy >= VA + VF && oy < VA + VF + VS) ? VP : !VP);
        chk("sof", sof, live && (r.pos % FRAME == 0));
        chk("vga_rgb", vga_rgb, de ? fb[oy][ox] : 0);
    endtask

    // Hand-computed timeline after reset release with en held high
    task automatic check_literals();
        case (cyc)
            3:   chk("lit_sof_pre", sof, 0);
            4:   begin
                     chk("lit_sof_first", sof, 1);
                     chk("lit_de_first", vga_de, 1);
                     chk("lit_rgb_first", vga_rgb, fb[0][0]);
                 end
            13:  chk("lit_hs_pre", vga_hsync, 1);
            14:  chk("lit_hs_start", vga_hsync, 0);
            16:  chk("lit_hs_last", vga_hsync, 0);
            17:  chk("lit_hs_end", vga_hsync, 1);
            73:  chk("lit_vs_pre", vga_vsync, 0);
            74:  chk("lit_vs_start", vga_vsync, 1);
            101: chk("lit_vs_last", vga_vsync, 1);
            102: chk("lit_vs_end", vga_vsync, 0);
            111: chk("lit_frame0", frame_cnt, 0);
            112: chk("lit_frame1", frame_cnt, 1);
            115: chk("lit_sof_gap", sof, 0);
            116: chk("lit_sof_second", sof, 1);
            default: ;
        endcase
    endtask

    task automatic step(input bit en_v);
        en = en_v;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            hq.delete();
            t   = 0;
            cyc = 0;
        end else begin
            hist.push_back('{live: en_v, pos: t});
            if (en_v) t++;
            cyc++;
        end
        #1;
        // framebuffer model: returns the addressed pixel PIPE cycles later
        if (req_valid === 1'b1 && req_x < HA && req_y < VA)
            hq.push_back(fb[req_y][req_x]);
        else
            hq.push_back(PW'($urandom));
        if (hq.size() > PIPE)
            pix_in = hq.pop_front();
        else
            pix_in = PW'($urandom);
        check_all();
        if (pin) check_literals();
    endtask

    initial begin
        bit found;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                fb[y][x] = PW'($urandom);

        // reset held
        for (int i = 0; i < 3; i++) step(1'b0);

        // release, free-running for over two frames
        rst = 1'b0;
        pin = 1'b1;
        for (int i = 0; i < 250; i++) step(1'b1);
        pin = 1'b0;

        // pause with req_x == 4 inside the active area
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            step(1'b1);
            if (((t - 1) % HT == 4) && (((t - 1) / HT) % VT < VA)) found = 1'b1;
        end
        chk("seek_pause", found, 1);
        for (int i = 0; i < 20; i++) step(1'b0);
        for (int i = 0; i < 30; i++) step(1'b1);

        // random enable pattern
        for (int i = 0; i < 600; i++) step($urandom_range(0, 3) != 0);

        // run to counter value vcnt=3, hcnt=6, then assert reset mid-cycle
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            step(1'b1);
            if ((t % HT == 6) && ((t / HT) % VT == 3)) found = 1'b1;
        end
        chk("seek_reset", found, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req_valid", req_valid, 0);
        chk("arst_req_x", req_x, 0);
        chk("arst_hsync", vga_hsync, !HP);
        chk("arst_vsync", vga_vsync, !VP);
        chk("arst_de", vga_de, 0);
        chk("arst_rgb", vga_rgb, 0);
        chk("arst_frame", frame_cnt, 0);
        for (int i = 0; i < 2; i++) step(1'b1);
        rst = 1'b0;
        pin = 1'b1;
        for (int i = 0; i < 150; i++) step(1'b1);
        pin = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
